// File: rtl/control_fsm_pkg.sv
`default_nettype none
// ============================================================================
// control_fsm_pkg : state, opcode, ALU, immediate and mux-select encodings
// Revision 1.0
// ============================================================================
package control_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMREAD = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECR   = 4'd6,
    S_EXECI   = 4'd7,
    S_ALUWB   = 4'd8,
    S_JAL     = 4'd9,
    S_JALR    = 4'd10,
    S_JALRPC  = 4'd11,
    S_BRANCH  = 4'd12,
    S_LUI     = 4'd13,
    S_AUIPC   = 4'd14
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_RTYPE = 2'd2,
    ALUOP_ITYPE = 2'd3
  } aluop_t;

  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_rtype  = 7'b0110011;
  localparam logic [6:0] c_op_itype  = 7'b0010011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;

  localparam logic [3:0] c_alu_add  = 4'b0000;
  localparam logic [3:0] c_alu_sub  = 4'b0001;
  localparam logic [3:0] c_alu_and  = 4'b0010;
  localparam logic [3:0] c_alu_or   = 4'b0011;
  localparam logic [3:0] c_alu_xor  = 4'b0100;
  localparam logic [3:0] c_alu_slt  = 4'b0101;
  localparam logic [3:0] c_alu_sltu = 4'b0110;
  localparam logic [3:0] c_alu_sll  = 4'b0111;
  localparam logic [3:0] c_alu_srl  = 4'b1000;
  localparam logic [3:0] c_alu_sra  = 4'b1001;

  localparam logic [2:0] c_imm_i = 3'b000;
  localparam logic [2:0] c_imm_s = 3'b001;
  localparam logic [2:0] c_imm_b = 3'b010;
  localparam logic [2:0] c_imm_j = 3'b011;
  localparam logic [2:0] c_imm_u = 3'b100;

  localparam logic [1:0] c_srca_pc    = 2'b00;
  localparam logic [1:0] c_srca_oldpc = 2'b01;
  localparam logic [1:0] c_srca_a     = 2'b10;
  localparam logic [1:0] c_srca_zero  = 2'b11;

  localparam logic [1:0] c_srcb_wd    = 2'b00;
  localparam logic [1:0] c_srcb_imm   = 2'b01;
  localparam logic [1:0] c_srcb_four  = 2'b10;

  localparam logic [1:0] c_res_aluout = 2'b00;
  localparam logic [1:0] c_res_data   = 2'b01;
  localparam logic [1:0] c_res_alures = 2'b10;

  localparam logic c_adr_pc     = 1'b0;
  localparam logic c_adr_result = 1'b1;

  localparam logic [2:0] c_f3_beq  = 3'b000;
  localparam logic [2:0] c_f3_bne  = 3'b001;
  localparam logic [2:0] c_f3_blt  = 3'b100;
  localparam logic [2:0] c_f3_bge  = 3'b101;
  localparam logic [2:0] c_f3_bltu = 3'b110;
  localparam logic [2:0] c_f3_bgeu = 3'b111;

  // Carry=1 means no borrow, so unsigned less-than is !Carry.
  function automatic logic branch_taken(input logic [2:0] f3,
                                        input logic z, input logic n,
                                        input logic c, input logic v);
    logic t;
    t = 1'b0;
    case (f3)
      c_f3_beq:  t = z;
      c_f3_bne:  t = ~z;
      c_f3_blt:  t = n ^ v;
      c_f3_bge:  t = ~(n ^ v);
      c_f3_bltu: t = ~c;
      c_f3_bgeu: t = c;
      default:   t = 1'b0;
    endcase
    return t;
  endfunction

endpackage
`default_nettype wire

// File: rtl/control_fsm_alu_decoder.sv
`default_nettype none
// ============================================================================
// alu_decoder : maps ALU operation class plus func3/func7b5 to ALUControl
// Revision 1.0
// ============================================================================
module alu_decoder
  import control_fsm_pkg::*;
(
  input  aluop_t     alu_op,
  input  logic [2:0] func3,
  input  logic       func7b5,
  output logic [3:0] alu_control
);

  logic [3:0] w_funct;

  // Immediate forms never subtract; func7b5 there is part of the immediate.
  always_comb begin
    w_funct = c_alu_add;
    case (func3)
      3'b000:  w_funct = (alu_op == ALUOP_RTYPE && func7b5) ? c_alu_sub : c_alu_add;
      3'b001:  w_funct = c_alu_sll;
      3'b010:  w_funct = c_alu_slt;
      3'b011:  w_funct = c_alu_sltu;
      3'b100:  w_funct = c_alu_xor;
      3'b101:  w_funct = func7b5 ? c_alu_sra : c_alu_srl;
      3'b110:  w_funct = c_alu_or;
      3'b111:  w_funct = c_alu_and;
      default: w_funct = c_alu_add;
    endcase
  end

  always_comb begin
    alu_control = c_alu_add;
    case (alu_op)
      ALUOP_ADD:   alu_control = c_alu_add;
      ALUOP_SUB:   alu_control = c_alu_sub;
      ALUOP_RTYPE: alu_control = w_funct;
      ALUOP_ITYPE: alu_control = w_funct;
      default:     alu_control = c_alu_add;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/control_fsm.sv
`default_nettype none
// ============================================================================
// control_fsm : multicycle RV32I control unit with retired-instruction counter
// Revision 1.0
// ============================================================================
module control_fsm
  import control_fsm_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  op,
  input  logic [2:0]  func3,
  input  logic        func7b5,
  input  logic        Zero,
  input  logic        Negative,
  input  logic        Carry,
  input  logic        Overflow,
  input  logic        mem_ready,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic        PCWrite,
  output logic        MemWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ImmSrc,
  output logic [3:0]  ALUControl,
  output logic        illegal,
  output logic [31:0] instret
);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_instret;

  logic        w_regwrite;
  logic        w_irwrite;
  logic        w_adrsrc;
  logic        w_pcwrite;
  logic        w_memwrite;
  logic [1:0]  w_ressrc;
  logic [1:0]  w_srca;
  logic [1:0]  w_srcb;
  logic [2:0]  w_immsrc;
  logic        w_illegal;
  aluop_t      w_alu_op;
  logic [3:0]  w_alu_control;
  logic        w_retire;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_regwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_adrsrc   = c_adr_pc;
    w_pcwrite  = 1'b0;
    w_memwrite = 1'b0;
    w_ressrc   = c_res_aluout;
    w_srca     = c_srca_pc;
    w_srcb     = c_srcb_wd;
    w_immsrc   = c_imm_i;
    w_illegal  = 1'b0;
    w_alu_op   = ALUOP_ADD;
    case (r_state)
      S_FETCH: begin
        w_srcb   = c_srcb_four;
        w_ressrc = c_res_alures;
        if (mem_ready) begin
          w_irwrite = 1'b1;
          w_pcwrite = 1'b1;
          w_next    = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target is precomputed into ALUOut while the opcode is decoded.
        w_srca   = c_srca_oldpc;
        w_srcb   = c_srcb_imm;
        w_immsrc = (op == c_op_jal) ? c_imm_j : c_imm_b;
        case (op)
          c_op_load, c_op_store: w_next = S_MEMADR;
          c_op_rtype:            w_next = S_EXECR;
          c_op_itype:            w_next = S_EXECI;
          c_op_jal:              w_next = S_JAL;
          c_op_jalr:             w_next = S_JALR;
          c_op_branch:           w_next = S_BRANCH;
          c_op_lui:              w_next = S_LUI;
          c_op_auipc:            w_next = S_AUIPC;
          default: begin
            w_illegal = 1'b1;
            w_next    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        w_srca   = c_srca_a;
        w_srcb   = c_srcb_imm;
        w_immsrc = (op == c_op_store) ? c_imm_s : c_imm_i;
        w_next   = (op == c_op_store) ? S_MEMWR : S_MEMREAD;
      end
      S_MEMREAD: begin
        w_adrsrc = c_adr_result;
        if (mem_ready) begin
          w_next = S_MEMWB;
        end
      end
      S_MEMWB: begin
        w_ressrc   = c_res_data;
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWR: begin
        w_adrsrc   = c_adr_result;
        w_memwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_EXECR: begin
        w_srca   = c_srca_a;
        w_srcb   = c_srcb_wd;
        w_alu_op = ALUOP_RTYPE;
        w_next   = S_ALUWB;
      end
      S_EXECI: begin
        w_srca   = c_srca_a;
        w_srcb   = c_srcb_imm;
        w_immsrc = c_imm_i;
        w_alu_op = ALUOP_ITYPE;
        w_next   = S_ALUWB;
      end
      S_ALUWB: begin
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_JAL, S_JALRPC: begin
        w_pcwrite = 1'b1;
        w_srca    = c_srca_oldpc;
        w_srcb    = c_srcb_four;
        w_next    = S_ALUWB;
      end
      S_JALR: begin
        w_srca   = c_srca_a;
        w_srcb   = c_srcb_imm;
        w_immsrc = c_imm_i;
        w_next   = S_JALRPC;
      end
      S_BRANCH: begin
        w_srca    = c_srca_a;
        w_srcb    = c_srcb_wd;
        w_alu_op  = ALUOP_SUB;
        w_pcwrite = branch_taken(func3, Zero, Negative, Carry, Overflow);
        w_next    = S_FETCH;
      end
      S_LUI: begin
        w_srca   = c_srca_zero;
        w_srcb   = c_srcb_imm;
        w_immsrc = c_imm_u;
        w_next   = S_ALUWB;
      end
      S_AUIPC: begin
        w_srca   = c_srca_oldpc;
        w_srcb   = c_srcb_imm;
        w_immsrc = c_imm_u;
        w_next   = S_ALUWB;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (w_alu_op),
    .func3       (func3),
    .func7b5     (func7b5),
    .alu_control (w_alu_control)
  );

  assign w_retire = (r_state == S_MEMWB) || (r_state == S_MEMWR) ||
                    (r_state == S_ALUWB) || (r_state == S_BRANCH);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_instret <= 32'd0;
    end else if (w_retire) begin
      r_instret <= r_instret + 32'd1;
    end
  end

  // Every strobe and select is forced low while reset is held.
  assign RegWrite   = w_regwrite & ~reset;
  assign IRWrite    = w_irwrite  & ~reset;
  assign AdrSrc     = w_adrsrc   & ~reset;
  assign PCWrite    = w_pcwrite  & ~reset;
  assign MemWrite   = w_memwrite & ~reset;
  assign illegal    = w_illegal  & ~reset;
  assign ResultSrc  = reset ? 2'b00   : w_ressrc;
  assign ALUSrcA    = reset ? 2'b00   : w_srca;
  assign ALUSrcB    = reset ? 2'b00   : w_srcb;
  assign ImmSrc     = reset ? 3'b000  : w_immsrc;
  assign ALUControl = reset ? 4'b0000 : w_alu_control;
  assign instret    = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_control_fsm.sv
`default_nettype none
// ============================================================================
// tb_control_fsm : table-driven, scoreboarded checks of the control FSM
// Revision 1.0
// ============================================================================
module tb_control_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  op;
  logic [2:0]  func3;
  logic        func7b5;
  logic        Zero, Negative, Carry, Overflow;
  logic        mem_ready;
  logic        RegWrite, IRWrite, AdrSrc, PCWrite, MemWrite, illegal;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0]  ImmSrc;
  logic [3:0]  ALUControl;
  logic [31:0] instret;

  always #5 clk = ~clk;

  control_fsm dut (
    .clk(clk), .reset(reset), .op(op), .func3(func3), .func7b5(func7b5),
    .Zero(Zero), .Negative(Negative), .Carry(Carry), .Overflow(Overflow),
    .mem_ready(mem_ready), .RegWrite(RegWrite), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .PCWrite(PCWrite), .MemWrite(MemWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .illegal(illegal),
    .instret(instret)
  );

  // {RegWrite,IRWrite,AdrSrc,PCWrite,MemWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,illegal}
  function automatic logic [18:0] ctl(input logic rw, input logic ir, input logic adr,
                                      input logic pcw, input logic mw, input logic [1:0] rs,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [2:0] imm, input logic [3:0] alu,
                                      input logic ill);
    return {rw, ir, adr, pcw, mw, rs, sa, sb, imm, alu, ill};
  endfunction

  localparam logic [18:0] F_RDY    = ctl(0,1,0,1,0, 2'b10, 2'b00, 2'b10, 3'b000, 4'h0, 0);
  localparam logic [18:0] F_WAIT   = ctl(0,0,0,0,0, 2'b10, 2'b00, 2'b10, 3'b000, 4'h0, 0);
  localparam logic [18:0] DEC_B    = ctl(0,0,0,0,0, 2'b00, 2'b01, 2'b01, 3'b010, 4'h0, 0);
  localparam logic [18:0] DEC_J    = ctl(0,0,0,0,0, 2'b00, 2'b01, 2'b01, 3'b011, 4'h0, 0);
  localparam logic [18:0] DEC_ILL  = ctl(0,0,0,0,0, 2'b00, 2'b01, 2'b01, 3'b010, 4'h0, 1);
  localparam logic [18:0] ALUWB    = ctl(1,0,0,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 4'h0, 0);
  localparam logic [18:0] MEMADR_L = ctl(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, 4'h0, 0);
  localparam logic [18:0] MEMADR_S = ctl(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b001, 4'h0, 0);
  localparam logic [18:0] MEMRD    = ctl(0,0,1,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 4'h0, 0);
  localparam logic [18:0] MEMWB    = ctl(1,0,0,0,0, 2'b01, 2'b00, 2'b00, 3'b000, 4'h0, 0);
  localparam logic [18:0] MEMWR    = ctl(0,0,1,0,1, 2'b00, 2'b00, 2'b00, 3'b000, 4'h0, 0);
  localparam logic [18:0] JAL_C    = ctl(0,0,0,1,0, 2'b00, 2'b01, 2'b10, 3'b000, 4'h0, 0);
  localparam logic [18:0] JALR_C   = ctl(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, 4'h0, 0);
  localparam logic [18:0] LUI_C    = ctl(0,0,0,0,0, 2'b00, 2'b11, 2'b01, 3'b100, 4'h0, 0);
  localparam logic [18:0] AUIPC_C  = ctl(0,0,0,0,0, 2'b00, 2'b01, 2'b01, 3'b100, 4'h0, 0);
  localparam logic [18:0] ZERO     = 19'd0;

  typedef struct {
    string       name;
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [3:0]  flags;   // {Z,N,C,V}
    logic        mr;
    logic [18:0] ctl;
    logic        chk_ir;
    logic [31:0] ir;
  } vec_t;

  vec_t        vecs[$];
  vec_t        sb[$];
  int          nvec = 0;
  int          nerr = 0;
  logic [31:0] n_ret = 32'd0;
  string       tag;
  logic [6:0]  c_op;
  logic [2:0]  c_f3;
  logic        c_f7;
  logic [3:0]  c_flags;

  wire [18:0] w_act = {RegWrite, IRWrite, AdrSrc, PCWrite, MemWrite, ResultSrc,
                       ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal};

  function void instr(input string t, input logic [6:0] o, input logic [2:0] f,
                      input logic f7, input logic [3:0] fl);
    tag = t; c_op = o; c_f3 = f; c_f7 = f7; c_flags = fl;
  endfunction

  function void push(input string step, input logic rst, input logic mr,
                     input logic [18:0] c);
    vec_t v;
    v.name = {tag, ".", step}; v.rst = rst; v.op = c_op; v.f3 = c_f3; v.f7 = c_f7;
    v.flags = c_flags; v.mr = mr; v.ctl = c; v.chk_ir = 1'b1; v.ir = n_ret;
    vecs.push_back(v);
  endfunction

  function void fetch(input int stalls);
    for (int i = 0; i < stalls; i++) push("fetchwait", 0, 0, F_WAIT);
    push("fetch", 0, 1, F_RDY);
  endfunction

  function void r_op(input string t, input logic [2:0] f, input logic f7, input logic [3:0] alu);
    instr(t, 7'b0110011, f, f7, 4'b0000);
    fetch(0); push("decode", 0, 1, DEC_B);
    push("execr", 0, 1, ctl(0,0,0,0,0, 2'b00, 2'b10, 2'b00, 3'b000, alu, 0));
    push("aluwb", 0, 1, ALUWB); n_ret++;
  endfunction

  function void i_op(input string t, input logic [2:0] f, input logic f7, input logic [3:0] alu);
    instr(t, 7'b0010011, f, f7, 4'b0000);
    fetch(0); push("decode", 0, 1, DEC_B);
    push("execi", 0, 1, ctl(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, alu, 0));
    push("aluwb", 0, 1, ALUWB); n_ret++;
  endfunction

  function void br(input string t, input logic [2:0] f, input logic [3:0] fl, input logic tk);
    instr(t, 7'b1100011, f, 1'b0, fl);
    fetch(0); push("decode", 0, 1, DEC_B);
    push("branch", 0, 1, ctl(0,0,0,tk,0, 2'b00, 2'b10, 2'b00, 3'b000, 4'h1, 0)); n_ret++;
  endfunction

  function void lw(input int stalls);
    instr("lw", 7'b0000011, 3'b010, 1'b0, 4'b0000);
    fetch(0); push("decode", 0, 1, DEC_B); push("memadr", 0, 1, MEMADR_L);
    for (int i = 0; i < stalls; i++) push("memread_stall", 0, 0, MEMRD);
    push("memread", 0, 1, MEMRD); push("memwb", 0, 1, MEMWB); n_ret++;
  endfunction

  task automatic apply(input vec_t v);
    vec_t e;
    @(posedge clk); #1;
    reset = v.rst; op = v.op; func3 = v.f3; func7b5 = v.f7;
    {Zero, Negative, Carry, Overflow} = v.flags; mem_ready = v.mr;
    sb.push_back(v);
    @(negedge clk);
    nvec++;
    if (sb.size() == 0) begin
      nerr++;
      $display("FAIL scoreboard empty at vector %0d", nvec);
    end else begin
      e = sb.pop_front();
      if (w_act !== e.ctl) begin
        nerr++;
        $display("FAIL %s controls actual=%b required=%b", e.name, w_act, e.ctl);
      end
      if (e.chk_ir && instret !== e.ir) begin
        nerr++;
        $display("FAIL %s instret actual=%0d required=%0d", e.name, instret, e.ir);
      end
    end
  endtask

  task automatic run_all();
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);
    vecs.delete();
  endtask

  initial begin
    reset = 1'b1; op = '0; func3 = '0; func7b5 = 1'b0;
    {Zero, Negative, Carry, Overflow} = 4'b0000; mem_ready = 1'b0;
    repeat (2) @(posedge clk);

    instr("reset", 7'b0110011, 3'b000, 1'b0, 4'b0000);
    push("held", 1, 1, ZERO);

    instr("add", 7'b0110011, 3'b000, 1'b0, 4'b0000);
    fetch(2); push("decode", 0, 1, DEC_B);
    push("execr", 0, 1, ctl(0,0,0,0,0, 2'b00, 2'b10, 2'b00, 3'b000, 4'h0, 0));
    push("aluwb", 0, 1, ALUWB); n_ret++;
    r_op("sub",  3'b000, 1, 4'h1);
    r_op("sll",  3'b001, 0, 4'h7);
    r_op("slt",  3'b010, 0, 4'h5);
    r_op("sltu", 3'b011, 0, 4'h6);
    r_op("xor",  3'b100, 0, 4'h4);
    r_op("srl",  3'b101, 0, 4'h8);
    r_op("sra",  3'b101, 1, 4'h9);
    r_op("or",   3'b110, 0, 4'h3);
    r_op("and",  3'b111, 0, 4'h2);
    i_op("addi_f7", 3'b000, 1, 4'h0);
    i_op("srli",    3'b101, 0, 4'h8);
    i_op("srai",    3'b101, 1, 4'h9);
    i_op("andi",    3'b111, 1, 4'h2);
    lw(3);
    lw(0);
    instr("sw", 7'b0100011, 3'b010, 1'b0, 4'b0000);
    fetch(0); push("decode", 0, 1, DEC_B); push("memadr", 0, 1, MEMADR_S);
    push("memwr", 0, 1, MEMWR); n_ret++;
    br("beq_t",   3'b000, 4'b1000, 1);
    br("beq_n",   3'b000, 4'b0000, 0);
    br("bne_t",   3'b001, 4'b0000, 1);
    br("blt_nv",  3'b100, 4'b0101, 0);
    br("blt_n",   3'b100, 4'b0100, 1);
    br("bge_nv",  3'b101, 4'b0101, 1);
    br("bltu_c0", 3'b110, 4'b0000, 1);
    br("bgeu_c0", 3'b111, 4'b0000, 0);
    br("bgeu_c1", 3'b111, 4'b0010, 1);
    br("f3_010",  3'b010, 4'b1111, 0);
    instr("jal", 7'b1101111, 3'b000, 1'b0, 4'b0000);
    fetch(0); push("decode", 0, 1, DEC_J); push("jal", 0, 1, JAL_C);
    push("aluwb", 0, 1, ALUWB); n_ret++;
    instr("jalr", 7'b1100111, 3'b000, 1'b0, 4'b0000);
    fetch(0); push("decode", 0, 1, DEC_B); push("jalr", 0, 1, JALR_C);
    push("jalrpc", 0, 1, JAL_C); push("aluwb", 0, 1, ALUWB); n_ret++;
    instr("lui", 7'b0110111, 3'b000, 1'b0, 4'b0000);
    fetch(0); push("decode", 0, 1, DEC_B); push("lui", 0, 1, LUI_C);
    push("aluwb", 0, 1, ALUWB); n_ret++;
    instr("auipc", 7'b0010111, 3'b000, 1'b0, 4'b0000);
    fetch(0); push("decode", 0, 1, DEC_B); push("auipc", 0, 1, AUIPC_C);
    push("aluwb", 0, 1, ALUWB); n_ret++;
    instr("ill0", 7'b0000000, 3'b000, 1'b0, 4'b0000);
    fetch(0); push("decode", 0, 1, DEC_ILL);
    instr("ill7f", 7'b1111111, 3'b000, 1'b0, 4'b0000);
    fetch(0); push("decode", 0, 1, DEC_ILL);
    instr("after_ill", 7'b0110011, 3'b000, 1'b0, 4'b0000);
    fetch(0);
    run_all();

    // Reset landing on the MEMWR cycle: no write strobe, counter cleared.
    instr("sw_rst", 7'b0100011, 3'b010, 1'b0, 4'b0000);
    push("decode", 0, 1, DEC_B);
    push("memadr", 0, 1, MEMADR_S);
    push("memwr_reset", 1, 1, ZERO);
    run_all();
    n_ret = 32'd0;
    r_op("add_post", 3'b000, 0, 4'h0);

    // Reset during a MEMREAD stall aborts the load before any RegWrite.
    instr("lw_rst", 7'b0000011, 3'b010, 1'b0, 4'b0000);
    fetch(0); push("decode", 0, 1, DEC_B); push("memadr", 0, 1, MEMADR_L);
    push("memread_stall", 0, 0, MEMRD); push("memread_stall", 0, 0, MEMRD);
    push("reset", 1, 0, ZERO);
    run_all();
    n_ret = 32'd0;
    instr("lw_rst", 7'b0000011, 3'b010, 1'b0, 4'b0000);
    push("fetch_after", 0, 1, F_RDY);
    push("decode_after", 0, 1, DEC_B);
    run_all();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have inputs op[6:0], func3[2:0] and func7b5, all from the instruction register.
REQ-004 SHALL have inputs Zero, Negative, Carry and Overflow: ALU flags, where Carry=1 means no borrow on a subtract.
REQ-005 SHALL have input mem_ready, 1 bit: memory read data is valid this cycle.
REQ-006 SHALL have outputs RegWrite, IRWrite, AdrSrc, PCWrite and MemWrite, each 1 bit.
REQ-007 SHALL have outputs ResultSrc[1:0], ALUSrcA[1:0], ALUSrcB[1:0], ImmSrc[2:0] and ALUControl[3:0].
REQ-008 SHALL have output illegal, 1 bit: a one-cycle pulse when an unsupported opcode is decoded.
REQ-009 SHALL have output instret[31:0]: count of retired instructions.

Function
REQ-010 Mux encodings SHALL be:
- ALUSrcA: 00=PC, 01=OldPC, 10=A, 11=zero.
- ALUSrcB: 00=WriteData, 01=ImmExt, 10=4.
- ResultSrc: 00=ALUOut, 01=Data, 10=ALUResult.
- AdrSrc: 0=PC, 1=Result.
REQ-011 ImmSrc SHALL be 000=I, 001=S, 010=B, 011=J, 100=U.
REQ-012 ALUControl SHALL be 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra.
REQ-013 States SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, JAL, JALR, JALRPC, BRANCH, LUI and AUIPC.
REQ-014 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
- IRWrite and PCWrite SHALL be asserted only when mem_ready=1.
- The FSM SHALL hold in FETCH while mem_ready=0, then go to DECODE.
REQ-015 DECODE: ALUSrcA=01, ALUSrcB=01, add.
- ImmSrc SHALL be J when op=1101111, otherwise B.
- Next state by op: 0000011/0100011 to MEMADR, 0110011 to EXECR, 0010011 to EXECI, 1101111 to JAL, 1100111 to JALR, 1100011 to BRANCH, 0110111 to LUI, 0010111 to AUIPC.
- Any other op SHALL pulse illegal and go to FETCH.
REQ-016 MEMADR: ALUSrcA=10, ALUSrcB=01, add, ImmSrc I for a load and S for a store; next MEMREAD for a load, MEMWR for a store.
REQ-017 MEMREAD: AdrSrc=1, ResultSrc=00; hold until mem_ready=1, then go to MEMWB.
REQ-018 MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
REQ-019 MEMWR: AdrSrc=1, ResultSrc=00, MemWrite=1 for exactly one cycle, then FETCH.
REQ-020 EXECR: ALUSrcA=10, ALUSrcB=00, then ALUWB.
- ALUControl SHALL be decoded from func3, with func7b5 selecting sub for 000 and sra for 101.
REQ-021 EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc I, then ALUWB.
- func3 000 SHALL always decode to add; func7b5 SHALL select srl versus sra only for 101.
REQ-022 ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
REQ-023 JAL: PCWrite=1, ResultSrc=00, ALUSrcA=01, ALUSrcB=10, add, then ALUWB.
REQ-024 JALR: ALUSrcA=10, ALUSrcB=01, ImmSrc I, add, then JALRPC.
REQ-025 JALRPC: same outputs as JAL, then ALUWB; target bit 0 is not cleared.
REQ-026 BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, then FETCH.
- PCWrite SHALL be asserted in the same cycle iff taken.
- Taken is: beq Z, bne !Z, blt N^V, bge !(N^V), bltu !C, bgeu C.
- func3 010/011 SHALL be treated as not taken.
REQ-027 LUI: ALUSrcA=11, ALUSrcB=01, ImmSrc U, add, then ALUWB.
REQ-028 AUIPC: ALUSrcA=01, ALUSrcB=01, ImmSrc U, add, then ALUWB.
REQ-029 Outputs not listed for a state SHALL be 0, except PCWrite in BRANCH, which depends on flags.
REQ-030 instret SHALL increment by 1, wrapping from FFFFFFFF to 0, on the exit cycle of MEMWB, MEMWR, ALUWB and BRANCH.

Reset
REQ-031 While reset=1, all of the following SHALL be 0: RegWrite, IRWrite, PCWrite, MemWrite, illegal and every mux select.
REQ-032 On the first cycle after reset deasserts, the state SHALL be FETCH and instret SHALL be 0.
REQ-033 Reset asserted in any state, including mid-MEMREAD stall, SHALL abort the instruction with no register or memory write.

Structure
REQ-034 State encoding, opcode constants, ALUControl codes, ImmSrc codes and mux-select codes SHALL live in a shared package.
REQ-035 ALU-control decode SHALL be a separate combinational sub-module named alu_decoder.

Verification
REQ-036 add x3,x1,x2 with mem_ready=1 → states FETCH, DECODE, EXECR, ALUWB; RegWrite high in cycle 4 only; instret 0→1.
REQ-037 lw with mem_ready low for 3 cycles in MEMREAD → 3 extra stall cycles, then exactly one RegWrite pulse with ResultSrc=01.
REQ-038 beq with Zero=1 → PCWrite=1 in BRANCH; with Zero=0 → PCWrite=0; both return to FETCH.
REQ-039 blt with N=1, V=1 → not taken; bltu with C=0 → taken.
REQ-040 op=0000000 → illegal pulses for one cycle in DECODE, next state FETCH, instret unchanged.
REQ-041 reset pulsed during MEMWR → MemWrite=0 in the reset cycle, then FETCH with instret=0.
